// File: rtl/imm_gen_pkg.sv
// Shared format encodings and RV32 opcode constants for the immediate generator.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_R    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational format resolution and sign-extended immediate extraction.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b1
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  fmt_e fmt_sel;

  // R and NONE carry no immediate, so they fall through to zero.
  function automatic logic signed [31:0] raw_imm(input fmt_e f, input logic [31:0] ins);
    case (f)
      FMT_I:   return {{20{ins[31]}}, ins[31:20]};
      FMT_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   return {ins[31:12], 12'b0};
      FMT_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

  always_comb begin
    fmt_sel = FMT_NONE;
    if (AUTO_DECODE) begin
      case (instr[6:0])
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt_sel = FMT_I;
        OP_STORE:                            fmt_sel = FMT_S;
        OP_BRANCH:                           fmt_sel = FMT_B;
        OP_LUI, OP_AUIPC:                    fmt_sel = FMT_U;
        OP_JAL:                              fmt_sel = FMT_J;
        OP_REG:                              fmt_sel = FMT_R;
        default:                             fmt_sel = FMT_NONE;
      endcase
    end else begin
      case (sel)
        3'd0:    fmt_sel = FMT_I;
        3'd1:    fmt_sel = FMT_S;
        3'd2:    fmt_sel = FMT_B;
        3'd3:    fmt_sel = FMT_U;
        3'd4:    fmt_sel = FMT_J;
        default: fmt_sel = FMT_NONE;
      endcase
    end
  end

  assign fmt     = fmt_sel;
  assign illegal = (fmt_sel == FMT_NONE);
  assign imm     = XLEN'(raw_imm(fmt_sel, instr));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator: decode ahead of a main+skid two-entry output buffer.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 5,
  parameter bit AUTO_DECODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr_i,
  input  logic [2:0]       imm_sel_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);

  // Stage p0: combinational decode of the presented instruction
  logic [XLEN-1:0] imm_p0;
  logic [2:0]      fmt_p0;
  logic            ill_p0;

  imm_decode #(
    .XLEN        (XLEN),
    .AUTO_DECODE (AUTO_DECODE)
  ) u_decode (
    .instr   (instr_i),
    .sel     (imm_sel_i),
    .imm     (imm_p0),
    .fmt     (fmt_p0),
    .illegal (ill_p0)
  );

  // Stage p1: main output register plus skid entry
  logic             vld_p1;
  logic [XLEN-1:0]  imm_p1;
  logic [2:0]       fmt_p1;
  logic             ill_p1;
  logic [TAG_W-1:0] tag_p1;

  logic             skid_full;
  logic [XLEN-1:0]  skid_imm;
  logic [2:0]       skid_fmt;
  logic             skid_ill;
  logic [TAG_W-1:0] skid_tag;

  logic accept;

  assign in_ready = !skid_full;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      imm_p1    <= '0;
      fmt_p1    <= FMT_NONE;
      ill_p1    <= 1'b0;
      tag_p1    <= '0;
      skid_full <= 1'b0;
      skid_imm  <= '0;
      skid_fmt  <= FMT_NONE;
      skid_ill  <= 1'b0;
      skid_tag  <= '0;
    end else if (!vld_p1 || out_ready) begin
      // Main register is free this edge; the skid entry is older, so it wins.
      if (skid_full) begin
        vld_p1    <= 1'b1;
        imm_p1    <= skid_imm;
        fmt_p1    <= skid_fmt;
        ill_p1    <= skid_ill;
        tag_p1    <= skid_tag;
        skid_full <= 1'b0;
      end else if (accept) begin
        vld_p1 <= 1'b1;
        imm_p1 <= imm_p0;
        fmt_p1 <= fmt_p0;
        ill_p1 <= ill_p0;
        tag_p1 <= tag_i;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      skid_full <= 1'b1;
      skid_imm  <= imm_p0;
      skid_fmt  <= fmt_p0;
      skid_ill  <= ill_p0;
      skid_tag  <= tag_i;
    end
  end

  assign out_valid = vld_p1;
  assign imm_o     = imm_p1;
  assign fmt_o     = fmt_p1;
  assign illegal_o = ill_p1;
  assign tag_o     = tag_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: an auto-decode XLEN=32 instance and a select-driven XLEN=64 instance share one input stream.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [4:0]  tag;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  sel;
  logic [4:0]  tag;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, ill_a;
  logic [31:0] imm_a;
  logic [2:0]  fmt_a;
  logic [4:0]  tag_a;

  logic        in_ready_b, out_valid_b, ill_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;
  logic [4:0]  tag_b;

  int vectors = 0;
  int miscompares = 0;

  exp_t qa[$];
  exp_t qb[$];

  bit   hold_pending = 0;
  exp_t hold_snap;
  bit   rand_on = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .AUTO_DECODE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .instr_i(instr), .imm_sel_i(sel), .tag_i(tag),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .imm_o(imm_a), .fmt_o(fmt_a), .illegal_o(ill_a), .tag_o(tag_a)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .AUTO_DECODE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .instr_i(instr), .imm_sel_i(sel), .tag_i(tag),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .imm_o(imm_b), .fmt_o(fmt_b), .illegal_o(ill_b), .tag_o(tag_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: immediate value as a signed number built from the instruction fields.
  function automatic exp_t model(input logic [31:0] ins, input bit auto_dec,
                                 input logic [2:0] s, input logic [4:0] t);
    exp_t   e;
    int     f;
    longint v;
    if (auto_dec) begin
      case (ins[6:0])
        7'h13, 7'h03, 7'h67, 7'h73: f = 0;
        7'h23:                      f = 1;
        7'h63:                      f = 2;
        7'h37, 7'h17:               f = 3;
        7'h6F:                      f = 4;
        7'h33:                      f = 5;
        default:                    f = 7;
      endcase
    end else begin
      f = (s <= 3'd4) ? int'(s) : 7;
    end
    case (f)
      0:       v = longint'($signed(ins[31:20]));
      1:       v = longint'($signed({ins[31:25], ins[11:7]}));
      2:       v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3:       v = longint'($signed(ins[31:12])) * 4096;
      4:       v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default: v = 0;
    endcase
    e.imm = 64'(v);
    e.fmt = 3'(f);
    e.ill = (f == 7);
    e.tag = t;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid_a && out_ready) begin
        if (qa.size() == 0) check("a_unexpected_out", 64'(tag_a), 64'h1F);
        else begin
          e = qa.pop_front();
          check("a_imm", 64'(imm_a), 64'(e.imm[31:0]));
          check("a_fmt", 64'(fmt_a), 64'(e.fmt));
          check("a_ill", 64'(ill_a), 64'(e.ill));
          check("a_tag", 64'(tag_a), 64'(e.tag));
        end
      end
      if (out_valid_b && out_ready) begin
        if (qb.size() == 0) check("b_unexpected_out", 64'(tag_b), 64'h1F);
        else begin
          e = qb.pop_front();
          check("b_imm", imm_b, e.imm);
          check("b_fmt", 64'(fmt_b), 64'(e.fmt));
          check("b_ill", 64'(ill_b), 64'(e.ill));
          check("b_tag", 64'(tag_b), 64'(e.tag));
        end
      end
      if (hold_pending) begin
        check("a_hold_valid", 64'(out_valid_a), 64'd1);
        check("a_hold_data", {imm_a, fmt_a, ill_a, tag_a, 23'd0},
              {hold_snap.imm[31:0], hold_snap.fmt, hold_snap.ill, hold_snap.tag, 23'd0});
      end
      hold_pending = out_valid_a && !out_ready;
      hold_snap    = '{imm: 64'(imm_a), fmt: fmt_a, ill: ill_a, tag: tag_a};
      if (in_valid && in_ready_a) qa.push_back(model(instr, 1'b1, sel, tag));
      if (in_valid && in_ready_b) qb.push_back(model(instr, 1'b0, sel, tag));
    end else begin
      hold_pending = 0;
    end
  end

  // Presents one item and returns at the edge+1 after it was accepted by the 32-bit instance.
  task automatic drive_item(input logic [31:0] ins, input logic [2:0] s, input logic [4:0] t);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    instr    = ins;
    sel      = s;
    tag      = t;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready_a) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("drive_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11];
    logic [31:0] w;
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    w = $urandom;
    if ($urandom_range(0, 5) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  initial begin
    int wait_cnt;
    rst_n = 1'b0;
    in_valid = 1'b0;
    instr = '0;
    sel = '0;
    tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_in_ready", 64'(in_ready_a), 64'd1);
    check("rst_imm", 64'(imm_a), 64'd0);
    check("rst_fmt", 64'(fmt_a), 64'd7);
    check("rst_ill", 64'(ill_a), 64'd0);
    check("rst_tag", 64'(tag_a), 64'd0);
    check("rst_b_fmt", 64'(fmt_b), 64'd7);
    rst_n = 1'b1;

    drive_item(32'hFFF00093, 3'd0, 5'd1);
    check("i_valid", 64'(out_valid_a), 64'd1);
    check("i_imm", 64'(imm_a), 64'hFFFFFFFF);
    check("i_fmt", 64'(fmt_a), 64'd0);
    check("i_imm64", imm_b, 64'hFFFFFFFFFFFFFFFF);
    drive_item(32'hFE20AE23, 3'd1, 5'd2);
    check("s_imm", 64'(imm_a), 64'hFFFFFFFC);
    check("s_fmt", 64'(fmt_a), 64'd1);
    drive_item(32'h123452B7, 3'd3, 5'd3);
    check("u_imm", 64'(imm_a), 64'h12345000);
    check("u_fmt", 64'(fmt_a), 64'd3);
    drive_item(32'hFFDFF0EF, 3'd4, 5'd4);
    check("j_valid", 64'(out_valid_a), 64'd1);
    check("j_imm", 64'(imm_a), 64'hFFFFFFFC);
    check("j_fmt", 64'(fmt_a), 64'd4);
    drive_item(32'h0000007F, 3'd6, 5'd5);
    check("ill_a_flag", 64'(ill_a), 64'd1);
    check("ill_a_imm", 64'(imm_a), 64'd0);
    check("ill_a_fmt", 64'(fmt_a), 64'd7);
    check("ill_b_flag", 64'(ill_b), 64'd1);
    check("ill_b_imm", imm_b, 64'd0);
    check("ill_b_fmt", 64'(fmt_b), 64'd7);
    @(posedge clk);
    #1;
    check("idle_out_valid", 64'(out_valid_a), 64'd0);

    // Stall: two items fill main+skid, the third waits.
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00500093; sel = 3'd0; tag = 5'd10;
    @(posedge clk); #1;
    instr = 32'h00A00113; tag = 5'd11;
    @(posedge clk); #1;
    check("stall_in_ready", 64'(in_ready_a), 64'd0);
    instr = 32'hFFF00193; tag = 5'd12;
    repeat (3) @(posedge clk);
    #1;
    check("stall_in_ready_hold", 64'(in_ready_a), 64'd0);
    check("stall_head_tag", 64'(tag_a), 64'd10);
    out_ready = 1'b1;
    drive_item(32'hFFF00193, 3'd0, 5'd12);
    repeat (3) @(posedge clk);
    #1;

    // Reset while both entries hold items.
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00100093; tag = 5'd20;
    @(posedge clk); #1;
    instr = 32'h00200093; tag = 5'd21;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_in_ready", 64'(in_ready_a), 64'd0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid_a), 64'd0);
    check("arst_in_ready", 64'(in_ready_a), 64'd1);
    check("arst_b_out_valid", 64'(out_valid_b), 64'd0);
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_stale", 64'(out_valid_a), 64'd0);
    end
    drive_item(32'h7FF00093, 3'd0, 5'd22);
    check("post_rst_latency", 64'(out_valid_a), 64'd1);
    check("post_rst_tag", 64'(tag_a), 64'd22);

    // Randomized traffic with random backpressure.
    rand_on = 1;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
          drive_item(rand_instr(), 3'($urandom_range(0, 7)), 5'($urandom));
        end
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_cnt = 0;
    while ((qa.size() != 0 || qb.size() != 0) && wait_cnt < 50) begin
      @(posedge clk);
      wait_cnt++;
    end
    #1;
    check("drain_a", 64'(qa.size()), 64'd0);
    check("drain_b", 64'(qb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
